button_conditioner: RTL and testbench

Front-end conditioning for the Basys3 push-buttons that feed the lab calculator and later datapath labs. Each raw, asynchronous, bouncing button input is synchronized, debounced, and converted into a clean level plus single-cycle press and release pulses. These are the events the calculator consumes: `btnd` commits the result, and `btnu` clears the accumulator. One instance serves all buttons, with an independent channel per button.

---
 rtl/btn_defs.sv | 15 +
 rtl/debounce_channel.sv | 102 ++++++++++
 rtl/button_conditioner.sv | 46 ++++
 tb/tb_button_conditioner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_defs.sv
// Shared definitions for the push-button conditioning front end.
package btn_defs;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;

  // 10 ms of stability at a 100 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One button: two-flop synchronizer, debounce FSM with stability counter,
// and registered level / press / release outputs.
module debounce_channel
  import btn_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_pressNext
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  btn_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic       r_level;
  logic       r_press;
  logic       r_release;
  logic       w_pressNext;
  logic       w_releaseNext;

  // Accept conditions: the synchronized level has held long enough in a WAIT state.
  always_comb begin
    w_pressNext   = 1'b0;
    w_releaseNext = 1'b0;
    if (r_state == WAIT_HIGH && r_sync2 && r_cnt == CNT_MAX) begin
      w_pressNext = 1'b1;
    end
    if (r_state == WAIT_LOW && !r_sync2 && r_cnt == CNT_MAX) begin
      w_releaseNext = 1'b1;
    end
  end

  // Synchronizer, debounce FSM, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_press   <= w_pressNext;
      r_release <= w_releaseNext;
      case (r_state)
        LOW: begin
          if (r_sync2) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!r_sync2) begin
            r_state <= LOW;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= HIGH;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!r_sync2) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (r_sync2) begin
            r_state <= HIGH;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= LOW;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= LOW;
        end
      endcase
    end
  end

  assign o_level     = r_level;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_pressNext = w_pressNext;

endmodule

// File: rtl/button_conditioner.sv
// Conditions all board push-buttons: one independent debounce channel per
// button plus a combined press strobe aligned with the per-button pulses.
module button_conditioner
  import btn_defs::*;
#(
  parameter int NUM_BUTTONS     = 5,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_in,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic                   any_press
);

  logic [NUM_BUTTONS-1:0] w_pressNext;
  logic                   r_anyPress;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_btn      (btn_in[gi]),
      .o_level    (btn_level[gi]),
      .o_press    (btn_press[gi]),
      .o_release  (btn_release[gi]),
      .o_pressNext(w_pressNext[gi])
    );
  end

  // Register the OR of next-state press bits so it lines up with btn_press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anyPress <= 1'b0;
    end else begin
      r_anyPress <= |w_pressNext;
    end
  end

  assign any_press = r_anyPress;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a short debounce window.
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int DC = 4;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;

  int nChecks = 0;
  int nFails  = 0;

  button_conditioner #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a change is accepted once the synchronized input has
  // disagreed with the current level on DC+1 consecutive sampling edges.
  logic [NB-1:0] mS1, mS2, mLevel, mPress, mRelease, mLast;
  logic          mAny;
  int            mRun [NB];

  // Advance the reference model on every rising edge.
  always @(posedge clk) begin : model
    logic [NB-1:0] tLevel, tPress, tRelease, tLast;
    int            tRun [NB];
    if (rst) begin
      mS1      <= '0;
      mS2      <= '0;
      mLevel   <= '0;
      mPress   <= '0;
      mRelease <= '0;
      mLast    <= '0;
      mAny     <= 1'b0;
      for (int i = 0; i < NB; i++) mRun[i] <= 0;
    end else begin
      tLevel   = mLevel;
      tLast    = mLast;
      tPress   = '0;
      tRelease = '0;
      for (int i = 0; i < NB; i++) begin
        tRun[i] = mRun[i];
        if (mS2[i] == tLast[i]) begin
          tRun[i] = tRun[i] + 1;
        end else begin
          tRun[i]  = 1;
          tLast[i] = mS2[i];
        end
        if (mS2[i] != tLevel[i] && tRun[i] >= DC + 1) begin
          tLevel[i]   = mS2[i];
          tPress[i]   = mS2[i];
          tRelease[i] = ~mS2[i];
        end
        mRun[i] <= tRun[i];
      end
      mLevel   <= tLevel;
      mLast    <= tLast;
      mPress   <= tPress;
      mRelease <= tRelease;
      mAny     <= |tPress;
      mS2      <= mS1;
      mS1      <= btn_in;
    end
  end

  // Drive inputs for one rising edge; returns positioned at the falling edge.
  task automatic applyStimulus(input logic [NB-1:0] v, input logic r);
    btn_in = v;
    rst    = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a value long enough for every channel to settle.
  task automatic settle(input logic [NB-1:0] v);
    for (int k = 0; k < 3 * DC + 4; k++) applyStimulus(v, 1'b0);
  endtask

  task automatic test_reset();
    for (int e = 0; e < 3; e++) begin
      applyStimulus(NB'($urandom), 1'b1);
      nChecks++;
      if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0 || any_press !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL reset_outputs: got lvl=%b prs=%b rel=%b any=%b, want all 0",
                 btn_level, btn_press, btn_release, any_press);
      end
    end
    applyStimulus('0, 1'b0);
  endtask

  task automatic test_clean_press();
    settle('0);
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(5'b00001, 1'b0);
      nChecks++;
      if (btn_press !== ((e == 7) ? 5'b00001 : 5'b00000) || any_press !== (e == 7)
          || btn_level !== ((e >= 7) ? 5'b00001 : 5'b00000)) begin
        nFails++;
        $display("[TB] FAIL clean_press e%0d: got prs=%b any=%b lvl=%b, want press only at e7",
                 e, btn_press, any_press, btn_level);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int         pulses;
    pat    = 6'b101101;
    pulses = 0;
    settle('0);
    for (int e = 1; e <= 20; e++) begin
      applyStimulus((e <= 6) ? {pat[6-e], 4'b0000} : 5'b10000, 1'b0);
      if (btn_press[4]) pulses++;
      nChecks++;
      if (btn_press[4] !== (e == 12) || btn_level[4] !== (e >= 12)) begin
        nFails++;
        $display("[TB] FAIL bounce e%0d: got prs4=%b lvl4=%b, want press at e12",
                 e, btn_press[4], btn_level[4]);
      end
    end
    nChecks++;
    if (pulses !== 1) begin
      nFails++;
      $display("[TB] FAIL bounce_count: got %0d pulses, want 1", pulses);
    end
  endtask

  task automatic test_release();
    settle(5'b00001);
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(5'b00000, 1'b0);
      nChecks++;
      if (btn_release !== ((e == 7) ? 5'b00001 : 5'b00000) || btn_press !== '0
          || btn_level[0] !== (e < 7)) begin
        nFails++;
        $display("[TB] FAIL release e%0d: got rel=%b prs=%b lvl=%b, want release only at e7",
                 e, btn_release, btn_press, btn_level);
      end
    end
  endtask

  task automatic test_boundary_glitch();
    settle(5'b00100);
    // Low for DC input cycles: never reaches DC+1 agreeing samples.
    for (int e = 1; e <= 14; e++) begin
      applyStimulus((e <= DC) ? 5'b00000 : 5'b00100, 1'b0);
      nChecks++;
      if (btn_release !== '0 || btn_press !== '0 || btn_level !== 5'b00100) begin
        nFails++;
        $display("[TB] FAIL glitch_short e%0d: got rel=%b prs=%b lvl=%b, want no change",
                 e, btn_release, btn_press, btn_level);
      end
    end
    // Low for DC+1 input cycles: accepted, then the return high is a new press.
    for (int e = 1; e <= 16; e++) begin
      applyStimulus((e <= DC + 1) ? 5'b00000 : 5'b00100, 1'b0);
      nChecks++;
      if (btn_release[2] !== (e == 7) || btn_press[2] !== (e == 12)
          || btn_level[2] !== (e < 7 || e >= 12)) begin
        nFails++;
        $display("[TB] FAIL glitch_long e%0d: got rel2=%b prs2=%b lvl2=%b, want rel e7 press e12",
                 e, btn_release[2], btn_press[2], btn_level[2]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int anyCount;
    anyCount = 0;
    settle('0);
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(5'b01010, 1'b0);
      if (any_press) anyCount++;
      nChecks++;
      if (btn_press !== ((e == 7) ? 5'b01010 : 5'b00000) || any_press !== (e == 7)) begin
        nFails++;
        $display("[TB] FAIL simultaneous e%0d: got prs=%b any=%b, want 01010/1 at e7",
                 e, btn_press, any_press);
      end
    end
    nChecks++;
    if (anyCount !== 1) begin
      nFails++;
      $display("[TB] FAIL simultaneous_any: got %0d any_press pulses, want 1", anyCount);
    end
  endtask

  task automatic test_reset_mid();
    settle(5'b00100);
    for (int e = 1; e <= 5; e++) applyStimulus(5'b00101, 1'b0);
    applyStimulus(5'b00101, 1'b1);
    nChecks++;
    if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0 || any_press !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_mid: got lvl=%b prs=%b rel=%b any=%b, want all 0",
               btn_level, btn_press, btn_release, any_press);
    end
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(5'b00101, 1'b0);
      nChecks++;
      if (btn_press !== ((e == 7) ? 5'b00101 : 5'b00000)
          || btn_level !== ((e >= 7) ? 5'b00101 : 5'b00000)) begin
        nFails++;
        $display("[TB] FAIL reset_held e%0d: got prs=%b lvl=%b, want 00101 from e7",
                 e, btn_press, btn_level);
      end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] cur;
    int            hold [NB];
    logic          r;
    cur = '0;
    for (int i = 0; i < NB; i++) hold[i] = 1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NB; i++) begin
        hold[i] = hold[i] - 1;
        if (hold[i] <= 0) begin
          cur[i]  = ~cur[i];
          hold[i] = int'($urandom_range(1, 2 * DC + 3));
        end
      end
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(cur, r);
      nChecks++;
      if (btn_level !== mLevel || btn_press !== mPress || btn_release !== mRelease
          || any_press !== mAny || (btn_press & btn_release) !== '0) begin
        nFails++;
        $display("[TB] FAIL random c%0d: got lvl=%b prs=%b rel=%b any=%b, want lvl=%b prs=%b rel=%b any=%b",
                 c, btn_level, btn_press, btn_release, any_press, mLevel, mPress, mRelease, mAny);
      end
    end
  endtask

  initial begin
    btn_in = '0;
    rst    = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_boundary_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
